// File: rtl/sprite_anim_sequencer.sv
// Sprite-sheet animation sequencer: steps through frames on vsync falling
// edges with a programmable per-frame hold, and produces a registered ROM
// address plus in-sprite flag for the current beam position.
module sprite_anim_sequencer #(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 64,
  parameter int NUM_FRAMES = 8,
  parameter int ADDR_W     = 19,
  parameter int HOLD_W     = 4
) (
  input  logic                          vga_clk,
  input  logic                          reset_n,
  input  logic                          vsync,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic [9:0]                    pos_x,
  input  logic [9:0]                    pos_y,
  input  logic                          start,
  input  logic                          loop,
  input  logic [HOLD_W-1:0]             hold,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
  output logic [ADDR_W-1:0]             rom_address,
  output logic                          in_sprite
);

  localparam int FI_W     = $clog2(NUM_FRAMES);
  localparam int FRAME_SZ = SPR_W * SPR_H;
  localparam logic [FI_W-1:0] LAST_FRAME = FI_W'(NUM_FRAMES - 1);
  localparam logic [10:0]     SPR_W11    = 11'(SPR_W);
  localparam logic [10:0]     SPR_H11    = 11'(SPR_H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_FINISH
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_vsync_q;
  logic                w_frame_tick;
  logic                r_loop, w_loop_nxt;
  logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;
  logic [HOLD_W-1:0]   w_hold_eff;
  logic [FI_W-1:0]     r_frame, w_frame_nxt;

  logic [10:0]         w_dx, w_dy;
  logic                w_inside;
  logic [ADDR_W-1:0]   w_addr;
  logic [ADDR_W-1:0]   r_rom_address;
  logic                r_in_sprite;

  assign w_frame_tick = r_vsync_q & ~vsync;
  assign w_hold_eff   = (hold == '0) ? HOLD_W'(1) : hold;

  // vsync edge detector register
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) r_vsync_q <= 1'b1;
    else          r_vsync_q <= vsync;
  end

  // Sequencer state and playback registers
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_frame    <= '0;
      r_hold_cnt <= '0;
      r_hold     <= '0;
      r_loop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_frame    <= w_frame_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_hold     <= w_hold_nxt;
      r_loop     <= w_loop_nxt;
    end
  end

  // Next-state logic; start from any state wins over a coincident tick
  always_comb begin
    w_state_nxt    = r_state;
    w_frame_nxt    = r_frame;
    w_hold_cnt_nxt = r_hold_cnt;
    w_hold_nxt     = r_hold;
    w_loop_nxt     = r_loop;
    if (start) begin
      w_loop_nxt     = loop;
      w_hold_nxt     = w_hold_eff;
      w_frame_nxt    = '0;
      w_hold_cnt_nxt = w_hold_eff - HOLD_W'(1);
      w_state_nxt    = S_PLAY;
    end else begin
      case (r_state)
        S_PLAY: begin
          if (w_frame_tick) begin
            if (r_hold_cnt != '0) begin
              w_hold_cnt_nxt = r_hold_cnt - HOLD_W'(1);
            end else begin
              w_hold_cnt_nxt = r_hold - HOLD_W'(1);
              if (r_frame != LAST_FRAME) w_frame_nxt = r_frame + FI_W'(1);
              else if (r_loop)           w_frame_nxt = '0;
              else                       w_state_nxt = S_FINISH;
            end
          end
        end
        S_FINISH: w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_PLAY);
  assign done      = (r_state == S_FINISH) & ~start;
  assign frame_idx = r_frame;

  // Box test uses 11-bit sums so a sprite at the screen edge cannot wrap
  always_comb begin
    w_dx     = {1'b0, DrawX} - {1'b0, pos_x};
    w_dy     = {1'b0, DrawY} - {1'b0, pos_y};
    w_inside = (DrawX >= pos_x) & ({1'b0, DrawX} < ({1'b0, pos_x} + SPR_W11)) &
               (DrawY >= pos_y) & ({1'b0, DrawY} < ({1'b0, pos_y} + SPR_H11));
    w_addr   = ADDR_W'(r_frame) * ADDR_W'(FRAME_SZ) +
               ADDR_W'(w_dy) * ADDR_W'(SPR_W) + ADDR_W'(w_dx);
  end

  // Registered ROM address and in-sprite flag, one cycle behind DrawX/DrawY
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_address <= '0;
      r_in_sprite   <= 1'b0;
    end else begin
      r_rom_address <= w_inside ? w_addr : '0;
      r_in_sprite   <= w_inside;
    end
  end

  assign rom_address = r_rom_address;
  assign in_sprite   = r_in_sprite;

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
module tb_sprite_anim_sequencer;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vsync   = 1'b1;
  logic [9:0]  DrawX   = '0;
  logic [9:0]  DrawY   = '0;
  logic [9:0]  pos_x   = '0;
  logic [9:0]  pos_y   = '0;
  logic        start   = 1'b0;
  logic        loop    = 1'b0;
  logic [3:0]  hold    = '0;
  logic        busy, done, in_sprite;
  logic [2:0]  frame_idx;
  logic [18:0] rom_address;

  int nvec = 0;
  int nerr = 0;
  logic done_seen = 1'b0;

  sprite_anim_sequencer #(
    .SPR_W(64), .SPR_H(64), .NUM_FRAMES(8), .ADDR_W(19), .HOLD_W(4)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .vsync(vsync),
    .DrawX(DrawX), .DrawY(DrawY), .pos_x(pos_x), .pos_y(pos_y),
    .start(start), .loop(loop), .hold(hold),
    .busy(busy), .done(done), .frame_idx(frame_idx),
    .rom_address(rom_address), .in_sprite(in_sprite)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct packed {
    logic [2:0]  frame;
    logic [9:0]  px, py, dx, dy;
    logic [18:0] addr;
    logic        ins;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    vsync = 1'b0;
    @(negedge vga_clk);
    done_seen = done_seen | done;
    vsync = 1'b1;
    @(negedge vga_clk);
    done_seen = done_seen | done;
  endtask

  task automatic pulse_start(input logic lp, input logic [3:0] h);
    start = 1'b1; loop = lp; hold = h;
    @(negedge vga_clk);
    start = 1'b0;
  endtask

  task automatic goto_frame(input int f);
    pulse_start(1'b1, 4'd0);
    repeat (f) tick();
    check("goto_frame", int'(frame_idx), f);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cur_frame;
    //            frame px   py   dx    dy    addr   ins
    vt[0]  = '{3'd0, 10'd100, 10'd50, 10'd110, 10'd53, 19'd202, 1'b1};
    vt[1]  = '{3'd0, 10'd100, 10'd50, 10'd163, 10'd113, 19'd4095, 1'b1};
    vt[2]  = '{3'd0, 10'd100, 10'd50, 10'd164, 10'd53, 19'd0, 1'b0};
    vt[3]  = '{3'd0, 10'd100, 10'd50, 10'd99, 10'd53, 19'd0, 1'b0};
    vt[4]  = '{3'd0, 10'd100, 10'd50, 10'd110, 10'd114, 19'd0, 1'b0};
    vt[5]  = '{3'd2, 10'd100, 10'd50, 10'd110, 10'd53, 19'd8394, 1'b1};
    vt[6]  = '{3'd2, 10'd100, 10'd50, 10'd164, 10'd53, 19'd0, 1'b0};
    vt[7]  = '{3'd2, 10'd600, 10'd450, 10'd639, 10'd479, 19'd10087, 1'b1};
    vt[8]  = '{3'd2, 10'd600, 10'd450, 10'd5, 10'd479, 19'd0, 1'b0};
    vt[9]  = '{3'd2, 10'd600, 10'd450, 10'd639, 10'd5, 19'd0, 1'b0};
    vt[10] = '{3'd5, 10'd10, 10'd20, 10'd10, 10'd19, 19'd0, 1'b0};
    vt[11] = '{3'd7, 10'd0, 10'd0, 10'd0, 10'd0, 19'd28672, 1'b1};
    vt[12] = '{3'd7, 10'd0, 10'd0, 10'd63, 10'd63, 19'd32767, 1'b1};
    vt[13] = '{3'd7, 10'd1000, 10'd1000, 10'd1023, 10'd1023, 19'd30167, 1'b1};

    // Reset state
    repeat (3) @(negedge vga_clk);
    check("rst_frame", int'(frame_idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(rom_address), 0);
    check("rst_in", int'(in_sprite), 0);
    reset_n = 1'b1;
    @(negedge vga_clk);

    // Address path vectors
    cur_frame = -1;
    for (int i = 0; i < 14; i++) begin
      if (int'(vt[i].frame) != cur_frame) begin
        goto_frame(int'(vt[i].frame));
        cur_frame = int'(vt[i].frame);
      end
      pos_x = vt[i].px; pos_y = vt[i].py; DrawX = vt[i].dx; DrawY = vt[i].dy;
      @(negedge vga_clk);
      check($sformatf("vec%0d_addr", i), int'(rom_address), int'(vt[i].addr));
      check($sformatf("vec%0d_in", i), int'(in_sprite), int'(vt[i].ins));
    end

    // One-shot, hold=2: each frame lasts two ticks
    pulse_start(1'b0, 4'd2);
    check("os_busy0", int'(busy), 1);
    check("os_frame0", int'(frame_idx), 0);
    done_seen = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      tick();
      check($sformatf("os_frame_t%0d", t), int'(frame_idx), t / 2);
    end
    check("os_busy_pre", int'(busy), 1);
    check("os_no_early_done", int'(done_seen), 0);
    vsync = 1'b0;
    @(negedge vga_clk);
    check("os_done_pulse", int'(done), 1);
    check("os_busy_fin", int'(busy), 0);
    check("os_frame_fin", int'(frame_idx), 7);
    vsync = 1'b1;
    @(negedge vga_clk);
    check("os_done_low", int'(done), 0);
    check("os_busy_idle", int'(busy), 0);
    tick(); tick();
    check("os_idle_hold", int'(frame_idx), 7);

    // Loop, hold=0: advance every tick, wrap, never done
    pulse_start(1'b1, 4'd0);
    done_seen = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      check($sformatf("lp_frame_t%0d", t), int'(frame_idx), t % 8);
    end
    check("lp_no_done", int'(done_seen), 0);
    check("lp_busy", int'(busy), 1);

    // Start coincident with a tick at frame 5 (hold counter at 0)
    pulse_start(1'b1, 4'd1);
    repeat (5) tick();
    check("rs_frame5", int'(frame_idx), 5);
    start = 1'b1; loop = 1'b1; hold = 4'd2; vsync = 1'b0;
    @(negedge vga_clk);
    start = 1'b0; vsync = 1'b1;
    check("rs_frame0", int'(frame_idx), 0);
    check("rs_busy", int'(busy), 1);
    @(negedge vga_clk);
    tick();
    check("rs_hold_reload", int'(frame_idx), 0);
    tick();
    check("rs_advance", int'(frame_idx), 1);

    // Start preempting FINISH suppresses done
    pulse_start(1'b0, 4'd1);
    repeat (7) tick();
    check("pf_frame7", int'(frame_idx), 7);
    vsync = 1'b0;
    @(negedge vga_clk);
    vsync = 1'b1;
    start = 1'b1; loop = 1'b0; hold = 4'd1;
    #1;
    check("pf_done_suppressed", int'(done), 0);
    @(negedge vga_clk);
    start = 1'b0;
    check("pf_busy", int'(busy), 1);
    check("pf_frame0", int'(frame_idx), 0);

    // Asynchronous reset mid-play at frame 3
    pulse_start(1'b1, 4'd0);
    repeat (3) tick();
    pos_x = 10'd0; pos_y = 10'd0; DrawX = 10'd1; DrawY = 10'd1;
    @(negedge vga_clk);
    check("ar_frame3", int'(frame_idx), 3);
    check("ar_addr_pre", int'(rom_address), 12353);
    reset_n = 1'b0;
    #1;
    check("ar_frame", int'(frame_idx), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_addr", int'(rom_address), 0);
    check("ar_in", int'(in_sprite), 0);
    @(negedge vga_clk);
    reset_n = 1'b1;
    tick(); tick(); tick();
    check("ar_idle_frame", int'(frame_idx), 0);
    check("ar_idle_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sprite_anim_sequencer.md
Name: sprite_anim_sequencer

Overview:
- Sequences a multi-frame sprite sheet held in one palettized ROM.
- Advances the animation frame on VGA vertical sync, honouring a per-frame hold count.
- Generates the registered ROM address and an in-sprite flag for the current DrawX/DrawY.
- Sits between the VGA controller and the sprite ROM/palette pair; frame changes never occur mid-frame (no tearing).

Parameters:
- SPR_W, 64, sprite width in pixels (power of 2)
- SPR_H, 64, sprite height in pixels
- NUM_FRAMES, 8, frames stored back-to-back in ROM, frame k at base k*SPR_W*SPR_H
- ADDR_W, 19, ROM address width
- HOLD_W, 4, width of the hold-count input

Ports:
- vga_clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- vsync  in  1  VGA vsync, active low; its falling edge marks frame start
- DrawX  in  10  current pixel x
- DrawY  in  10  current pixel y
- pos_x  in  10  sprite top-left x
- pos_y  in  10  sprite top-left y
- start  in  1  one-cycle pulse: begin playback at frame 0
- loop  in  1  sampled on start: 1 = wrap forever, 0 = one-shot
- hold  in  HOLD_W  sampled on start: display refreshes per frame (0 treated as 1)
- busy  out  1  high while PLAY
- done  out  1  one-cycle pulse when a one-shot completes
- frame_idx  out  $clog2(NUM_FRAMES)  current frame
- rom_address  out  ADDR_W  registered ROM address
- in_sprite  out  1  registered; high when the pixel lies inside the sprite box

Behaviour:
- Reset (async, reset_n=0): state IDLE; frame_idx=0; hold_cnt=0; busy=0; done=0; rom_address=0; in_sprite=0; vsync_q=1.
- frame_tick = vsync_q & ~vsync, where vsync_q is vsync registered once. It is a single-cycle pulse.
- State IDLE:
  - start=1: latch loop_r=loop and hold_r=max(hold,1); frame_idx<=0; hold_cnt<=hold_r-1; go to PLAY.
- State PLAY: busy=1.
  - On frame_tick with hold_cnt>0: decrement hold_cnt.
  - On frame_tick with hold_cnt==0: reload hold_cnt=hold_r-1.
    - If frame_idx<NUM_FRAMES-1: increment frame_idx.
    - Else if loop_r=1: frame_idx<=0.
    - Else: go to FINISH; frame_idx stays at the last frame.
- State FINISH: done=1 for exactly this cycle; go to IDLE. frame_idx holds the last frame until the next start.
- start in PLAY or FINISH restarts exactly as from IDLE, and takes priority over a simultaneous frame_tick. done is not asserted when FINISH is preempted by start.
- Address path, 1-cycle latency: values for (DrawX,DrawY) appear on rom_address/in_sprite at the next vga_clk edge.
  - dx=DrawX-pos_x and dy=DrawY-pos_y, computed in 11 bits.
  - inside = (DrawX>=pos_x) & ({1'b0,DrawX} < pos_x+SPR_W) & (DrawY>=pos_y) & ({1'b0,DrawY} < pos_y+SPR_H).
  - The compares use 11-bit sums, so sprites near x=639/y=479 do not wrap.
  - inside=1: rom_address <= frame_idx*SPR_W*SPR_H + dy*SPR_W + dx.
  - inside=0: rom_address <= 0.
  - in_sprite <= inside.
- The address path runs in every state. In IDLE it shows the held frame_idx.
- hold_cnt is HOLD_W bits. hold=2^HOLD_W-1 gives the maximum dwell time.

Test Plan:
- Reset check: assert reset_n=0 mid-PLAY at frame 3 -> immediately frame_idx=0, busy=0, rom_address=0, in_sprite=0; after release, stays IDLE with no tick-driven advance.
- One-shot playback: start with loop=0, hold=2 -> frame_idx steps 0..7 every 2 vsync falling edges. On the tick after 2 ticks at frame 7, done pulses exactly 1 cycle, busy falls, and frame_idx stays 7.
- Loop with hold=0: start with loop=1, hold=0 -> advance every tick; frame 7 wraps to 0; done never asserts over 20 ticks.
- Address generation: frame_idx=2, pos=(100,50), DrawX=110, DrawY=53 -> next cycle rom_address=2*4096+3*64+10=8394 and in_sprite=1. DrawX=164 -> in_sprite=0 and rom_address=0.
- Screen edge: pos=(600,450), DrawX=639, DrawY=479 -> in_sprite=1 and rom_address=frame_base+29*64+39. DrawX=5 -> in_sprite=0 (no wrap).
- Restart and simultaneous events: start coincident with frame_tick during PLAY at frame 5 -> frame_idx=0 and hold reloaded, with no advance on that tick.
